// File: rtl/rsa_uart_pkg.sv
// Shared types and defaults for the RSA/UART Avalon bridge.
// Build option RSA_FULL_OUT_EN (used by rsa_uart_bridge) sends every result byte.
package rsa_uart_pkg;

    typedef enum logic [2:0] {
        S_POLL_RX,
        S_READ_RX,
        S_CALC,
        S_POLL_TX,
        S_WRITE_TX
    } state_t;

    typedef enum logic [1:0] {
        PH_N,
        PH_D,
        PH_ENC
    } phase_t;

    localparam int AVM_ADDR_W = 5;
    localparam int AVM_DATA_W = 32;

    localparam int DEF_RX_ADDR     = 0;
    localparam int DEF_TX_ADDR     = 4;
    localparam int DEF_STATUS_ADDR = 8;
    localparam int DEF_TX_OK_BIT   = 6;
    localparam int DEF_RX_OK_BIT   = 7;

    // Operand load order: modulus, exponent, then ciphertext blocks.
    function automatic phase_t next_phase(input phase_t ph);
        case (ph)
            PH_N:    return PH_D;
            default: return PH_ENC;
        endcase
    endfunction

endpackage

// File: rtl/rsa_uart_bridge_if.sv
// Avalon-MM master bus between the bridge and the UART register block.
interface rsa_uart_bridge_if;

    logic [rsa_uart_pkg::AVM_ADDR_W-1:0] avm_address;
    logic                                avm_read;
    logic [rsa_uart_pkg::AVM_DATA_W-1:0] avm_readdata;
    logic                                avm_write;
    logic [rsa_uart_pkg::AVM_DATA_W-1:0] avm_writedata;
    logic                                avm_waitrequest;

    modport master (
        output avm_address, avm_read, avm_write, avm_writedata,
        input  avm_readdata, avm_waitrequest
    );

    modport slave (
        input  avm_address, avm_read, avm_write, avm_writedata,
        output avm_readdata, avm_waitrequest
    );

endinterface

// File: rtl/rsa_uart_bridge_avm_byte_port.sv
// Single-outstanding Avalon byte transfer engine: holds the strobes through
// waitrequest and reports completion with a one-cycle done and the read word.
module avm_byte_port
    import rsa_uart_pkg::*;
#(
    parameter int RESET_ADDR = DEF_STATUS_ADDR
) (
    input  logic                  avm_clk,
    input  logic                  avm_rst,
    rsa_uart_bridge_if.master     avm,
    input  logic                  req,
    input  logic                  req_write,
    input  logic [AVM_ADDR_W-1:0] req_addr,
    input  logic [7:0]            req_byte,
    output logic                  done,
    output logic [AVM_DATA_W-1:0] rdata
);

    logic [AVM_ADDR_W-1:0] address_reg;
    logic                  read_reg;
    logic                  write_reg;
    logic [AVM_DATA_W-1:0] writedata_reg;
    logic                  done_reg;
    logic [AVM_DATA_W-1:0] rdata_reg;

    // Leaves reset with a status read already in flight; a new request is
    // only accepted while idle, so the strobe drops for a cycle after each transfer.
    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) begin
            address_reg   <= AVM_ADDR_W'(RESET_ADDR);
            read_reg      <= 1'b1;
            write_reg     <= 1'b0;
            writedata_reg <= '0;
            done_reg      <= 1'b0;
            rdata_reg     <= '0;
        end else begin
            done_reg <= 1'b0;
            if (read_reg || write_reg) begin
                if (!avm.avm_waitrequest) begin
                    read_reg  <= 1'b0;
                    write_reg <= 1'b0;
                    done_reg  <= 1'b1;
                    rdata_reg <= avm.avm_readdata;
                end
            end else if (req) begin
                address_reg   <= req_addr;
                read_reg      <= !req_write;
                write_reg     <= req_write;
                writedata_reg <= {{(AVM_DATA_W-8){1'b0}}, req_byte};
            end
        end
    end

    assign avm.avm_address   = address_reg;
    assign avm.avm_read      = read_reg;
    assign avm.avm_write     = write_reg;
    assign avm.avm_writedata = writedata_reg;
    assign done              = done_reg;
    assign rdata             = rdata_reg;

endmodule

// File: rtl/rsa_uart_bridge.sv
// UART-fed modular-exponentiation bridge: loads N, D, then ciphertext blocks,
// runs the core and writes the result back. RSA_FULL_OUT_EN sends all result bytes.
module rsa_uart_bridge
    import rsa_uart_pkg::*;
#(
    parameter int KEY_BITS    = 256,
    parameter int RX_ADDR     = DEF_RX_ADDR,
    parameter int TX_ADDR     = DEF_TX_ADDR,
    parameter int STATUS_ADDR = DEF_STATUS_ADDR,
    parameter int TX_OK_BIT   = DEF_TX_OK_BIT,
    parameter int RX_OK_BIT   = DEF_RX_OK_BIT
) (
    input  logic                avm_clk,
    input  logic                avm_rst,
    rsa_uart_bridge_if.master   avm,
    input  logic                i_rekey,
    output logic                o_core_start,
    output logic [KEY_BITS-1:0] o_core_a,
    output logic [KEY_BITS-1:0] o_core_d,
    output logic [KEY_BITS-1:0] o_core_n,
    input  logic [KEY_BITS-1:0] i_core_result,
    input  logic                i_core_finished,
    output logic                o_busy
);

    localparam int BYTES = KEY_BITS / 8;
    localparam int CNT_W = $clog2(BYTES + 1);
`ifdef RSA_FULL_OUT_EN
    localparam int OUT_BYTES = BYTES;
    localparam int TX_MSB    = KEY_BITS - 1;
`else
    localparam int OUT_BYTES = BYTES - 1;
    localparam int TX_MSB    = KEY_BITS - 9;
`endif
    localparam logic [AVM_ADDR_W-1:0] A_RX     = AVM_ADDR_W'(RX_ADDR);
    localparam logic [AVM_ADDR_W-1:0] A_TX     = AVM_ADDR_W'(TX_ADDR);
    localparam logic [AVM_ADDR_W-1:0] A_STATUS = AVM_ADDR_W'(STATUS_ADDR);

    state_t                state_reg;
    phase_t                phase_reg;
    logic [CNT_W-1:0]      count_reg;
    logic                  rekey_reg;
    logic                  busy_reg;
    logic                  start_reg;
    logic [KEY_BITS-1:0]   n_reg;
    logic [KEY_BITS-1:0]   d_reg;
    logic [KEY_BITS-1:0]   a_reg;
    logic [KEY_BITS-1:0]   result_reg;
    logic                  req_reg;
    logic                  req_write_reg;
    logic [AVM_ADDR_W-1:0] req_addr_reg;
    logic [7:0]            req_byte_reg;

    logic                  port_done;
    logic [AVM_DATA_W-1:0] port_rdata;
    logic [CNT_W-1:0]      count_inc;
    logic [7:0]            rx_byte;
    logic                  rdata_unused;

    assign count_inc    = count_reg + CNT_W'(1);
    assign rx_byte      = port_rdata[7:0];
    assign rdata_unused = ^port_rdata;

    avm_byte_port #(
        .RESET_ADDR (STATUS_ADDR)
    ) u_port (
        .avm_clk   (avm_clk),
        .avm_rst   (avm_rst),
        .avm       (avm),
        .req       (req_reg),
        .req_write (req_write_reg),
        .req_addr  (req_addr_reg),
        .req_byte  (req_byte_reg),
        .done      (port_done),
        .rdata     (port_rdata)
    );

    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) begin
            state_reg     <= S_POLL_RX;
            phase_reg     <= PH_N;
            count_reg     <= '0;
            rekey_reg     <= 1'b0;
            busy_reg      <= 1'b0;
            start_reg     <= 1'b0;
            n_reg         <= '0;
            d_reg         <= '0;
            a_reg         <= '0;
            result_reg    <= '0;
            req_reg       <= 1'b0;
            req_write_reg <= 1'b0;
            req_addr_reg  <= A_STATUS;
            req_byte_reg  <= '0;
        end else begin
            req_reg   <= 1'b0;
            start_reg <= 1'b0;
            rekey_reg <= rekey_reg | i_rekey;
            case (state_reg)
                S_POLL_RX: begin
                    // Between blocks nothing is half-loaded, so a rekey can take effect at once.
                    if (i_rekey && phase_reg == PH_ENC && count_reg == '0) begin
                        phase_reg <= PH_N;
                        rekey_reg <= 1'b0;
                    end
                    if (port_done) begin
                        req_reg       <= 1'b1;
                        req_write_reg <= 1'b0;
                        if (port_rdata[RX_OK_BIT]) begin
                            state_reg    <= S_READ_RX;
                            req_addr_reg <= A_RX;
                        end else begin
                            req_addr_reg <= A_STATUS;
                        end
                    end
                end
                S_READ_RX: begin
                    if (port_done) begin
                        case (phase_reg)
                            PH_N:    n_reg <= {n_reg[KEY_BITS-9:0], rx_byte};
                            PH_D:    d_reg <= {d_reg[KEY_BITS-9:0], rx_byte};
                            default: begin
                                a_reg    <= {a_reg[KEY_BITS-9:0], rx_byte};
                                busy_reg <= 1'b1;
                            end
                        endcase
                        if (count_inc == CNT_W'(BYTES) && phase_reg == PH_ENC) begin
                            count_reg <= '0;
                            state_reg <= S_CALC;
                            start_reg <= 1'b1;
                        end else begin
                            if (count_inc == CNT_W'(BYTES)) begin
                                count_reg <= '0;
                                phase_reg <= next_phase(phase_reg);
                            end else begin
                                count_reg <= count_inc;
                            end
                            state_reg     <= S_POLL_RX;
                            req_reg       <= 1'b1;
                            req_write_reg <= 1'b0;
                            req_addr_reg  <= A_STATUS;
                        end
                    end
                end
                S_CALC: begin
                    if (i_core_finished) begin
                        result_reg    <= i_core_result;
                        state_reg     <= S_POLL_TX;
                        req_reg       <= 1'b1;
                        req_write_reg <= 1'b0;
                        req_addr_reg  <= A_STATUS;
                    end
                end
                S_POLL_TX: begin
                    if (port_done) begin
                        req_reg <= 1'b1;
                        if (port_rdata[TX_OK_BIT]) begin
                            state_reg     <= S_WRITE_TX;
                            req_write_reg <= 1'b1;
                            req_addr_reg  <= A_TX;
                            req_byte_reg  <= result_reg[TX_MSB -: 8];
                        end else begin
                            req_write_reg <= 1'b0;
                            req_addr_reg  <= A_STATUS;
                        end
                    end
                end
                S_WRITE_TX: begin
                    if (port_done) begin
                        result_reg    <= {result_reg[KEY_BITS-9:0], 8'h00};
                        req_reg       <= 1'b1;
                        req_write_reg <= 1'b0;
                        req_addr_reg  <= A_STATUS;
                        if (count_inc == CNT_W'(OUT_BYTES)) begin
                            count_reg <= '0;
                            busy_reg  <= 1'b0;
                            state_reg <= S_POLL_RX;
                            if (rekey_reg || i_rekey) begin
                                phase_reg <= PH_N;
                                rekey_reg <= 1'b0;
                            end else begin
                                phase_reg <= PH_ENC;
                            end
                        end else begin
                            count_reg <= count_inc;
                            state_reg <= S_POLL_TX;
                        end
                    end
                end
                default: state_reg <= S_POLL_RX;
            endcase
        end
    end

    assign o_core_start = start_reg;
    assign o_core_a     = a_reg;
    assign o_core_d     = d_reg;
    assign o_core_n     = n_reg;
    assign o_busy       = busy_reg;

endmodule
